// File: rtl/mac_dot_sequencer.sv
// Dot-product sequencer: drives one external qmac through clear, operand streaming and drain,
// then holds the captured accumulator and sticky overflow on a valid/ready result port.
module mac_dot_sequencer #(
    parameter int Q     = 0,
    parameter int N     = 2,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   out_result,
    output logic             out_overflow,
    output logic             mac_reset,
    output logic [N-1:0]     mac_a,
    output logic [N-1:0]     mac_b,
    input  logic [2*N-1:0]   mac_result,
    input  logic             mac_overflow
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] count;
    logic             live;
    logic             xfer;
    logic             accept;
    logic             last_pair;

    // Q only sets the qmac's fixed-point scaling; sequencing is independent of it.
    logic unused_q;
    assign unused_q = (Q != 0);

    assign xfer      = (state == S_RUN) && in_valid;
    assign accept    = start && ((state == S_IDLE) || ((state == S_DONE) && out_ready));
    assign last_pair = ((count + LEN_W'(1)) == len_r);

    always_comb begin
        state_nxt = state;
        busy      = (state != S_IDLE);
        in_ready  = (state == S_RUN);
        out_valid = (state == S_DONE);
        mac_reset = ~reset_n | (state == S_CLEAR);
        case (state)
            S_IDLE:    if (start) state_nxt = S_CLEAR;
            S_CLEAR:   state_nxt = (len_r != '0) ? S_RUN : S_CAPTURE;
            S_RUN:     if (xfer && last_pair) state_nxt = S_DRAIN;
            S_DRAIN:   state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = S_DONE;
            S_DONE:    if (out_ready) state_nxt = start ? S_CLEAR : S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            len_r        <= '0;
            count        <= '0;
            live         <= 1'b0;
            mac_a        <= '0;
            mac_b        <= '0;
            out_result   <= '0;
            out_overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                len_r <= len;
                count <= '0;
            end else if (xfer) begin
                count <= count + LEN_W'(1);
            end
            // Gaps and the post-drain cycle feed 0*0 so the accumulator holds its value.
            mac_a <= xfer ? in_a : '0;
            mac_b <= xfer ? in_b : '0;
            live  <= xfer;
            if (accept) begin
                out_overflow <= 1'b0;
            end else if (live && mac_overflow) begin
                out_overflow <= 1'b1;
            end
            if (state == S_CAPTURE) begin
                out_result <= mac_result;
            end
        end
    end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Bench for mac_dot_sequencer: an accumulator stand-in for qmac, a job-level reference model
// checked every cycle, directed scenarios with literal results, then randomized jobs.
module tb_mac_dot_sequencer;

    localparam int Q     = 0;
    localparam int N     = 2;
    localparam int LEN_W = 8;
    localparam int RW    = 2 * N;
    localparam int MINV  = -(1 << (RW - 1));
    localparam int RNG   = 1 << RW;
    localparam int MAXV  = MINV + RNG - 1;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_a;
    logic [N-1:0]     in_b;
    logic             out_valid;
    logic             out_ready;
    logic [RW-1:0]    out_result;
    logic             out_overflow;
    logic             mac_reset;
    logic [N-1:0]     mac_a;
    logic [N-1:0]     mac_b;
    logic [RW-1:0]    mac_result;
    logic             mac_overflow;

    mac_dot_sequencer #(.Q(Q), .N(N), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .len(len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_overflow(out_overflow), .mac_reset(mac_reset), .mac_a(mac_a), .mac_b(mac_b),
        .mac_result(mac_result), .mac_overflow(mac_overflow)
    );

    always #5 clk = ~clk;

    // qmac stand-in: wrapping 2N-bit accumulator, overflow flag on acc + current product.
    logic signed [RW-1:0] acc;
    logic signed [RW-1:0] prod;
    logic [RW:0]          acc_sum;
    assign prod         = $signed(mac_a) * $signed(mac_b);
    assign acc_sum      = {acc[RW-1], acc} + {prod[RW-1], prod};
    assign mac_result   = acc;
    assign mac_overflow = acc_sum[RW] ^ acc_sum[RW-1];
    always @(posedge clk) begin
        if (mac_reset) acc <= '0;
        else           acc <= acc_sum[RW-1:0];
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Job-level reference: timing follows from accept/transfer cycles, sums use plain integers.
    int m_active, m_running, m_pending, m_clear_cyc, m_done_cyc, m_left;
    int m_acc, m_ovf, m_prev_xfer, m_prev_a, m_prev_b;
    initial begin
        m_active = 0; m_running = 0; m_pending = 0; m_clear_cyc = -10; m_done_cyc = 0;
        m_left = 0; m_acc = 0; m_ovf = 0; m_prev_xfer = 0; m_prev_a = 0; m_prev_b = 0;
    end

    always @(negedge clk) begin
        int  s;
        bit  exp_ready, exp_valid, xf, hs;
        cyc++;
        if (!reset_n) begin
            chk("rst_busy", int'(busy), 0);
            chk("rst_in_ready", int'(in_ready), 0);
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_mac_reset", int'(mac_reset), 1);
            chk("rst_out_result", int'(out_result), 0);
            chk("rst_out_overflow", int'(out_overflow), 0);
            chk("rst_mac_a", int'(mac_a), 0);
            chk("rst_mac_b", int'(mac_b), 0);
            m_active = 0; m_running = 0; m_pending = 0; m_prev_xfer = 0; m_clear_cyc = -10;
        end else begin
            exp_ready = (m_running != 0) && (cyc > m_clear_cyc);
            exp_valid = (m_pending != 0) && (m_running == 0) && (cyc >= m_done_cyc);
            chk("busy", int'(busy), m_active);
            chk("in_ready", int'(in_ready), int'(exp_ready));
            chk("out_valid", int'(out_valid), int'(exp_valid));
            chk("mac_reset", int'(mac_reset), int'(cyc == m_clear_cyc));
            chk("mac_a", int'($signed(mac_a)), m_prev_xfer != 0 ? m_prev_a : 0);
            chk("mac_b", int'($signed(mac_b)), m_prev_xfer != 0 ? m_prev_b : 0);
            if (exp_valid) begin
                chk("out_result", int'($signed(out_result)), m_acc);
                chk("out_overflow", int'(out_overflow), m_ovf);
            end
            xf = in_valid && exp_ready;
            m_prev_xfer = int'(xf);
            m_prev_a = int'($signed(in_a));
            m_prev_b = int'($signed(in_b));
            if (xf) begin
                s = m_acc + m_prev_a * m_prev_b;
                if (s > MAXV || s < MINV) m_ovf = 1;
                m_acc = ((s - MINV) % RNG + RNG) % RNG + MINV;
                m_left--;
                if (m_left == 0) begin
                    m_running = 0;
                    m_done_cyc = cyc + 3;
                end
            end
            hs = exp_valid && out_ready;
            if (hs) begin
                m_pending = 0;
                m_active = 0;
            end
            if (start && (m_active == 0 || hs)) begin
                m_active = 1; m_pending = 1; m_clear_cyc = cyc + 1;
                m_left = int'(len); m_running = int'(len != 0);
                m_acc = 0; m_ovf = 0;
                if (len == 0) m_done_cyc = cyc + 3;
            end
        end
    end

    int qa [256];
    int qb [256];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int n);
        start = 1'b1;
        len   = LEN_W'(n);
        step();
        start = 1'b0;
    endtask

    task automatic feed(input int n, input int fixed_gap, input int maxgap, input bit noisy);
        int g, guard;
        bit rdy;
        for (int k = 0; k < n; k++) begin
            g = (fixed_gap >= 0) ? fixed_gap : int'($urandom_range(maxgap, 0));
            in_valid = 1'b0;
            repeat (g) begin
                if (noisy) start = $urandom_range(1, 0) != 0;
                step();
            end
            in_valid = 1'b1;
            in_a = N'(qa[k]);
            in_b = N'(qb[k]);
            guard = 0;
            do begin
                rdy = in_ready;
                if (noisy) start = $urandom_range(1, 0) != 0;
                step();
                guard++;
            end while (!rdy && guard < 20);
            if (!rdy) begin
                checks++;
                errors++;
                $display("FAIL in_ready_timeout at cycle %0d: got 0, expected 1", cyc);
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic get_result(output int res, output int ovf, input bit chain, input int next_len);
        int guard;
        guard = 0;
        while (!out_valid && guard < 50) begin
            step();
            guard++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL out_valid_timeout at cycle %0d: got 0, expected 1", cyc);
        end
        res = int'($signed(out_result));
        ovf = int'(out_overflow);
        repeat ($urandom_range(2, 0)) step();
        out_ready = 1'b1;
        if (chain) begin
            start = 1'b1;
            len   = LEN_W'(next_len);
        end
        step();
        out_ready = 1'b0;
        start     = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout at cycle %0d: got running, expected finished", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int res, ovf, n, chained;
        start = 1'b0; len = '0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        step();

        // 1: back-to-back pairs
        qa[0] = 1; qb[0] = 1; qa[1] = 1; qb[1] = 1; qa[2] = 1; qb[2] = -1; qa[3] = -1; qb[3] = -1;
        start_job(4);
        feed(4, 0, 0, 1'b0);
        get_result(res, ovf, 1'b0, 0);
        chk("t1_result", res, 2);
        chk("t1_overflow", ovf, 0);

        // 2: same vector with two-cycle gaps
        start_job(4);
        feed(4, 2, 0, 1'b0);
        get_result(res, ovf, 1'b0, 0);
        chk("t2_result", res, 2);
        chk("t2_overflow", ovf, 0);

        // 3: overflow
        qa[0] = -2; qb[0] = -2; qa[1] = -2; qb[1] = -2;
        start_job(2);
        feed(2, 0, 0, 1'b0);
        get_result(res, ovf, 1'b0, 0);
        chk("t3_overflow", ovf, 1);

        // 4: zero length
        start_job(0);
        get_result(res, ovf, 1'b0, 0);
        chk("t4_result", res, 0);
        chk("t4_overflow", ovf, 0);

        // 5: reset mid-run, then a fresh job
        qa[0] = 1; qb[0] = 1; qa[1] = 1; qb[1] = 1;
        start_job(4);
        feed(2, 0, 0, 1'b0);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        chk("t5_idle_busy", int'(busy), 0);
        qa[0] = 1; qb[0] = -1;
        start_job(1);
        feed(1, 0, 0, 1'b0);
        get_result(res, ovf, 1'b0, 0);
        chk("t5_result", res, -1);

        // 6: start ignored during run, back-to-back restart from DONE
        qa[0] = 1; qb[0] = 1; qa[1] = 1; qb[1] = -2;
        start_job(2);
        feed(2, 1, 0, 1'b1);
        get_result(res, ovf, 1'b1, 1);
        chk("t6_job1_result", res, -1);
        chk("t6_clear_next", int'(mac_reset), 1);
        qa[0] = -2; qb[0] = 1;
        feed(1, 0, 0, 1'b0);
        get_result(res, ovf, 1'b0, 0);
        chk("t6_job2_result", res, -2);
        chk("t6_job2_overflow", ovf, 0);

        // maximum length
        for (int k = 0; k < 255; k++) begin
            qa[k] = int'($urandom_range(3, 0)) - 2;
            qb[k] = int'($urandom_range(3, 0)) - 2;
        end
        start_job(255);
        feed(255, 0, 0, 1'b0);
        get_result(res, ovf, 1'b0, 0);

        // randomized jobs, some chained straight from DONE
        chained = 0;
        for (int j = 0; j < 40; j++) begin
            n = int'($urandom_range(6, 0));
            for (int k = 0; k < n; k++) begin
                qa[k] = int'($urandom_range(3, 0)) - 2;
                qb[k] = int'($urandom_range(3, 0)) - 2;
            end
            if (chained == 0) start_job(n);
            feed(n, -1, 2, $urandom_range(2, 0) == 0);
            chained = int'($urandom_range(1, 0));
            get_result(res, ovf, chained != 0, int'($urandom_range(6, 0)));
            if (chained != 0) begin
                n = int'(len);
                chained = 0;
                // a chained job was already accepted; finish it with fresh pairs
                for (int k = 0; k < 8; k++) begin
                    qa[k] = int'($urandom_range(3, 0)) - 2;
                    qb[k] = int'($urandom_range(3, 0)) - 2;
                end
                n = int'(dut.len_r);
                feed(n, -1, 1, 1'b0);
                get_result(res, ovf, 1'b0, 0);
            end
        end
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
